// File: rtl/seq_addsub_pkg.sv
// rtl/seq_addsub_pkg.sv - shared types and helpers for the chunked adder/subtractor
package seq_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A single-chunk configuration still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/seq_addsub_chunk_adder.sv
// rtl/seq_addsub_chunk_adder.sv - CHUNK-bit combinational ripple slice
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout     = c[CHUNK];
    // Only meaningful for the top chunk, where it feeds the signed-overflow flag.
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/seq_addsub.sv
// rtl/seq_addsub.sv - multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock
module seq_addsub
    import seq_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);

    if ((WIDTH % CHUNK) != 0 || WIDTH < 2 || CHUNK < 1) begin : g_bad_params
        $fatal(1, "seq_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [31:0]      base;
    logic [CHUNK-1:0] slice_a, slice_b, slice_sum;
    logic             slice_cout, slice_msb_in;

    assign base    = 32'(cnt_q) * 32'(CHUNK);
    assign slice_a = a_q[base +: CHUNK];
    assign slice_b = b_q[base +: CHUNK];

    chunk_adder #(.CHUNK(CHUNK)) u_slice (
        .a        (slice_a),
        .b        (slice_b),
        .cin      (carry_q),
        .sum      (slice_sum),
        .cout     (slice_cout),
        .c_msb_in (slice_msb_in)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1, so B is inverted once here.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[base +: CHUNK] = slice_sum;
                carry_d = slice_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(NCHUNK - 1)) begin
                    cout_d  = slice_cout;
                    ovf_d   = slice_msb_in ^ slice_cout;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
// tb/tb_seq_addsub.sv - self-checking bench for seq_addsub (8/4 directed, 32-bit sweeps)
module tb_seq_addsub;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rst_sw_n;
    logic       in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow;
    logic [7:0] a, b, sum;
    exp_t       sb[$];

    seq_addsub #(.WIDTH(8), .CHUNK(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: unexpected result 0x%0h", sum);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum", 64'(sum), 64'(e.s[7:0]));
                chk("cout", 64'(cout), 64'(e.co));
                chk("overflow", 64'(overflow), 64'(e.ov));
            end
        end
    end

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input logic ts, input exp_t e);
        int k;
        int lat;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_wait", 64'(in_ready), 64'd1);
        a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble inputs to show the block works from its own copies.
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk("in_ready_run", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency_8_4", 64'(lat), 64'd2);
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_sw
        localparam int CH = (gi == 0) ? 1 : (gi == 1) ? 8 : 32;
        logic        s_iv, s_ir, s_ov, s_or, s_cin, s_sub, s_co, s_of;
        logic [31:0] s_a, s_b, s_sum;
        exp_t        s_q[$];
        bit          done = 1'b0;

        seq_addsub #(.WIDTH(32), .CHUNK(CH)) u_dut (
            .clk       (clk),
            .rst_n     (rst_sw_n),
            .in_valid  (s_iv),
            .in_ready  (s_ir),
            .a         (s_a),
            .b         (s_b),
            .cin       (s_cin),
            .sub       (s_sub),
            .out_valid (s_ov),
            .out_ready (s_or),
            .sum       (s_sum),
            .cout      (s_co),
            .overflow  (s_of)
        );

        initial begin
            s_iv = 1'b0; s_or = 1'b1; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
            wait (rst_sw_n === 1'b1);
            @(posedge clk); #1;
            for (int i = 0; i < 1000; i++) begin
                exp_t        e;
                logic [32:0] r;
                logic [31:0] be;
                int          k;
                int          lat;
                s_a   = $urandom;
                s_b   = $urandom;
                s_cin = 1'($urandom_range(0, 1));
                s_sub = 1'($urandom_range(0, 1));
                be    = s_sub ? ~s_b : s_b;
                r     = {1'b0, s_a} + {1'b0, be} + 33'(s_sub ? 1'b1 : s_cin);
                e.s   = r[31:0];
                e.co  = r[32];
                e.ov  = (s_a[31] == be[31]) && (r[31] != s_a[31]);
                k = 0;
                while (!s_ir && k < 100) begin
                    @(posedge clk); #1;
                    k++;
                end
                chk($sformatf("sw%0d_ready", CH), 64'(s_ir), 64'd1);
                s_iv = 1'b1;
                s_q.push_back(e);
                @(posedge clk); #1;
                s_iv = 1'b0;
                s_a = $urandom; s_b = $urandom;
                lat = 0;
                while (!s_ov && lat < 64) begin
                    @(posedge clk); #1;
                    lat++;
                end
                chk($sformatf("sw%0d_latency", CH), 64'(lat), 64'(32 / CH));
            end
            for (int k = 0; k < 100 && s_q.size() != 0; k++) begin
                @(posedge clk); #1;
            end
            chk($sformatf("sw%0d_drained", CH), 64'(s_q.size()), 64'd0);
            done = 1'b1;
        end

        always @(negedge clk) begin
            if (rst_sw_n && s_ov && s_or) begin
                if (s_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sw%0d_underflow: unexpected result 0x%0h", CH, s_sum);
                end else begin
                    exp_t e;
                    e = s_q.pop_front();
                    chk($sformatf("sw%0d_sum", CH), 64'(s_sum), 64'(e.s));
                    chk($sformatf("sw%0d_cout", CH), 64'(s_co), 64'(e.co));
                    chk($sformatf("sw%0d_ovf", CH), 64'(s_of), 64'(e.ov));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        exp_t e;
        tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[2] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[3] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[4] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[5] = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0};
        tbl[6] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[7] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        tbl[8] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
        tbl[9] = '{8'h80, 8'hFF, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0};

        rst_n = 1'b0; rst_sw_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; rst_sw_n = 1'b1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);

        for (int i = 0; i < 10; i++) begin
            e.s = 32'(tbl[i].s); e.co = tbl[i].co; e.ov = tbl[i].ov;
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, e);
        end

        // Backpressure: result held, foreign in_valid ignored while DONE.
        @(posedge clk); #1;
        out_ready = 1'b0;
        e.s = 32'h60; e.co = 1'b1; e.ov = 1'b1;
        run_op(8'hC0, 8'hA0, 1'b0, 1'b0, e);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_sum", 64'(sum), 64'h60);
            chk("bp_cout", 64'(cout), 64'd1);
            chk("bp_overflow", 64'(overflow), 64'd1);
            in_valid = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("bp_no_accept", 64'(in_ready), 64'd1);
        chk("bp_sum_kept", 64'(sum), 64'h60);

        // Asynchronous reset during the first RUN cycle.
        a = 8'hAA; b = 8'h11; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_run_busy", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_sum", 64'(sum), 64'd0);
        chk("mid_rst_cout", 64'(cout), 64'd0);
        chk("mid_rst_overflow", 64'(overflow), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        e.s = 32'h46; e.co = 1'b0; e.ov = 1'b0;
        run_op(8'h12, 8'h34, 1'b0, 1'b0, e);
        @(posedge clk); #1;

        for (int k = 0; k < 60000; k++) begin
            if (g_sw[0].done && g_sw[1].done && g_sw[2].done) break;
            @(posedge clk); #1;
        end
        chk("sweeps_done", 64'({g_sw[0].done, g_sw[1].done, g_sw[2].done}), 64'b111);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
- Parameterised, multi-cycle adder/subtractor; successor to the single-bit full adder.
- Processes a WIDTH-bit operand pair CHUNK bits per clock through one CHUNK-bit ripple slice, with a registered carry between chunks.
- Valid/ready handshake on input and output, so it slots between datapath stages where area matters more than latency.
- Supports add and subtract modes with carry-out and signed-overflow flags.

Parameters:
- WIDTH, 32: operand/result width in bits. Must be a multiple of CHUNK, and at least 2.
- CHUNK, 8: bits processed per cycle. WIDTH == CHUNK gives single-cycle operation.

Ports:
- clk  in  1: clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- in_valid  in  1: operands presented.
- in_ready  out  1: block can accept operands.
- a  in  WIDTH: operand A.
- b  in  WIDTH: operand B.
- cin  in  1: carry-in. Used in add mode only.
- sub  in  1: 0 = A+B+cin; 1 = A-B (A + ~B + 1), cin ignored.
- out_valid  out  1: result valid.
- out_ready  in  1: consumer accepts result.
- sum  out  WIDTH: result, modulo 2^WIDTH.
- cout  out  1: carry out of MSB. In sub mode, 1 = no borrow (A >= B unsigned).
- overflow  out  1: two's-complement overflow of the signed interpretation.

Behaviour:
- Constants: NCHUNK = WIDTH/CHUNK; chunk counter width = clog2(NCHUNK), minimum 1.
- States: IDLE, RUN, DONE.
- Reset, asynchronous and taking effect mid-operation:
  - state = IDLE, counter = 0, carry register = 0, sum = 0, cout = 0, overflow = 0, out_valid = 0.
  - in_ready becomes 1 once reset is released.
  - Any in-flight operation is discarded.
- in_ready = (state == IDLE). out_valid = (state == DONE).
- Accept happens on an edge where in_valid && in_ready. On accept:
  - Latch a, and b XOR {WIDTH{sub}}.
  - Carry register = sub ? 1 : cin.
  - counter = 0; state becomes RUN.
- RUN, each cycle:
  - The slice adds chunk[counter] of A, chunk[counter] of the effective B, and the carry register.
  - The chunk result is written to sum bits [counter*CHUNK +: CHUNK], LSB chunk first.
  - Carry register takes the slice carry-out.
  - counter increments.
  - On the last chunk (counter == NCHUNK-1): cout = slice carry-out; overflow = carry into MSB XOR carry out of MSB; state becomes DONE.
- Latency: out_valid rises exactly NCHUNK clock edges after the accept edge. Example: WIDTH=8, CHUNK=4 gives valid 2 cycles after accept.
- DONE:
  - sum, cout and overflow are held stable while out_valid && !out_ready (backpressure; no change, no new accept).
  - On out_valid && out_ready, state becomes IDLE. sum, cout and overflow keep their last values until the next result is written.
- No overlap: a new operation can be accepted at the earliest one cycle after the output handshake.
- in_valid while busy is ignored. The source must hold its operands until in_ready is seen.
- The a, b, sub and cin inputs are don't-care outside the accept edge; internal copies are used.
- sum bits are written progressively during RUN. Consumers must sample only when out_valid is high.
- Elaboration check: WIDTH % CHUNK != 0 is a fatal error.

Decomposition:
- Shared package: state enum (IDLE/RUN/DONE) and a clog2-based helper for the counter width.
- One sub-module: chunk_adder (parameter CHUNK). Combinational ripple of full_adder instances with inputs a, b, cin and outputs sum, cout, and c_msb_in (the carry into the top bit, used for overflow).
- seq_addsub holds the FSM, operand registers, carry register and output registers.

Test Plan (WIDTH=8, CHUNK=4 unless noted):
- Add with wrap: a=0xFF, b=0x01, sub=0, cin=0 -> sum=0x00, cout=1, overflow=0; out_valid exactly 2 cycles after accept; in_ready=0 during RUN.
- Signed overflow and carry-in: a=0x7F, b=0x00, cin=1, sub=0 -> sum=0x80, cout=0, overflow=1. Then a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, overflow=1.
- Subtract, both directions: sub=1, a=0x80, b=0x01 -> sum=0x7F, cout=1, overflow=1 (cin=1 must not change the result). Then a=0x05, b=0x07 -> sum=0xFE, cout=0, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum, cout, overflow and out_valid stable, in_ready=0. Then release -> out_valid drops next cycle and in_ready=1 the same cycle. Also drive a new in_valid during DONE and confirm it is not accepted.
- Reset mid-operation: assert rst_n=0 asynchronously during the first RUN cycle -> out_valid=0, sum=0, cout=0, overflow=0 immediately. After release, 0x12+0x34 returns 0x46 with cout=0.
- Parameter sweep: WIDTH=32 with CHUNK ∈ {1, 8, 32} -> 1000 random add/sub vectors match the reference model; latency = 32, 4 and 1 cycles respectively.
